time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_pkg.sv | 41 ++++
 rtl/idle_timer.sv | 27 ++
 rtl/time_set_ctrl.sv | 144 ++++++++++++++
 tb/tb_time_set_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// Shared definitions for the keypad time-set controller: key codes, FSM encoding, digit limits.
// SECONDS_SET_EN selects six-digit HH:MM:SS entry instead of four-digit HH:MM.
package time_set_pkg;

    localparam logic [3:0] KEY_CONFIRM = 4'd10;
    localparam logic [3:0] KEY_CANCEL  = 4'd11;
    localparam logic [3:0] KEY_BACK    = 4'd13;
    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ENTRY   = 2'd1;
    localparam logic [1:0] ST_CONFIRM = 2'd2;
    localparam logic [1:0] ST_COMMIT  = 2'd3;

    localparam logic [3:0] LIM_HOUR_TENS     = 4'd2;
    localparam logic [3:0] LIM_HOUR_UNITS_20 = 4'd3;
    localparam logic [3:0] LIM_TENS          = 4'd5;
    localparam logic [3:0] LIM_UNITS         = 4'd9;

`ifdef SECONDS_SET_EN
    localparam int NUM_DIGITS = 6;
`else
    localparam int NUM_DIGITS = 4;
`endif

    // Position 0 is hour tens; a tens of 2 is refused if the stored units already exceed 3.
    function automatic logic digit_ok(input logic [2:0] pos, input logic [3:0] code,
                                      input logic [3:0] hr_tens, input logic [3:0] hr_units);
        logic ok;
        case (pos)
            3'd0:       ok = (code <= LIM_HOUR_TENS) &&
                             !((code == LIM_HOUR_TENS) && (hr_units > LIM_HOUR_UNITS_20));
            3'd1:       ok = (hr_tens == LIM_HOUR_TENS) ? (code <= LIM_HOUR_UNITS_20)
                                                        : (code <= LIM_UNITS);
            3'd2, 3'd4: ok = (code <= LIM_TENS);
            default:    ok = (code <= LIM_UNITS);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/idle_timer.sv
// Key-inactivity timer: counts 1 Hz ticks while enabled, flags expiry on the TIMEOUT_S-th tick.
module idle_timer #(
    parameter int TIMEOUT_S = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    input  logic enable,
    output logic expired
);
    localparam logic [5:0] LAST_CNT = 6'(TIMEOUT_S - 1);

    logic [5:0] cnt;

    // Expiry is flagged on the tick itself so the FSM leaves in that same cycle; a key wins.
    assign expired = enable && !clear && tick && (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst || clear || !enable || expired) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 6'd1;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Keypad-driven time-set controller: collects BCD HH:MM digits and hands them to the clock counter.
// Define SECONDS_SET_EN to add seconds entry (set_ss port, six digits).
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int         TIMEOUT_S = 10,
    parameter logic [3:0] KEY_A     = KEY_CONFIRM
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       set_ack,
    output logic       set_req,
    output logic [7:0] set_hh,
    output logic [7:0] set_mm,
`ifdef SECONDS_SET_EN
    output logic [7:0] set_ss,
`endif
    output logic [2:0] digit_pos,
    output logic [1:0] state,
    output logic       key_err
);
    localparam int         DW       = 4 * NUM_DIGITS;
    localparam logic [2:0] LAST_POS = 3'(NUM_DIGITS - 1);

    logic [DW-1:0] dig_q, dig_d;
    logic [1:0]    state_d;
    logic [2:0]    pos_d, pos_dec;
    logic          req_d, err_d, expired, timer_en, is_digit, digit_legal;
    logic [3:0]    hr_tens, hr_units;

    // Digit 0 (hour tens) occupies the most significant nibble.
    function automatic logic [DW-1:0] put_nibble(input logic [DW-1:0] v, input logic [2:0] pos,
                                                 input logic [3:0] val);
        logic [DW-1:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (pos == 3'(i)) r[DW-4-4*i +: 4] = val;
        end
        return r;
    endfunction

    assign hr_tens  = dig_q[DW-1 -: 4];
    assign hr_units = dig_q[DW-5 -: 4];
    assign set_hh   = dig_q[DW-1 -: 8];
    assign set_mm   = dig_q[DW-9 -: 8];
`ifdef SECONDS_SET_EN
    assign set_ss   = dig_q[7:0];
`endif

    assign is_digit    = (key_code <= KEY_DIGIT_MAX);
    assign digit_legal = digit_ok(digit_pos, key_code, hr_tens, hr_units);
    assign pos_dec     = digit_pos - 3'd1;
    assign timer_en    = (state == ST_ENTRY) || (state == ST_CONFIRM);

    idle_timer #(.TIMEOUT_S(TIMEOUT_S)) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (key_valid),
        .tick    (tick_1hz),
        .enable  (timer_en),
        .expired (expired)
    );

    // In CONFIRM digit_pos stays on the last digit, so backspace reopens exactly that digit.
    always_comb begin
        state_d = state;
        pos_d   = digit_pos;
        dig_d   = dig_q;
        req_d   = set_req;
        err_d   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (key_valid && (key_code == KEY_A)) begin
                    dig_d   = '0;
                    pos_d   = '0;
                    state_d = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (expired) begin
                    state_d = ST_IDLE;
                end else if (key_valid) begin
                    if (key_code == KEY_CANCEL) begin
                        state_d = ST_IDLE;
                    end else if (key_code == KEY_BACK) begin
                        if (digit_pos != 3'd0) begin
                            pos_d = pos_dec;
                            dig_d = put_nibble(dig_q, pos_dec, 4'd0);
                        end
                    end else if (is_digit) begin
                        if (digit_legal) begin
                            dig_d = put_nibble(dig_q, digit_pos, key_code);
                            if (digit_pos == LAST_POS) state_d = ST_CONFIRM;
                            else                       pos_d   = digit_pos + 3'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            ST_CONFIRM: begin
                if (expired) begin
                    state_d = ST_IDLE;
                end else if (key_valid) begin
                    if (key_code == KEY_CANCEL) begin
                        state_d = ST_IDLE;
                    end else if (key_code == KEY_A) begin
                        req_d   = 1'b1;
                        state_d = ST_COMMIT;
                    end else if (key_code == KEY_BACK) begin
                        dig_d   = put_nibble(dig_q, LAST_POS, 4'd0);
                        state_d = ST_ENTRY;
                    end
                end
            end
            default: begin
                if (set_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            set_req   <= 1'b0;
            dig_q     <= '0;
            digit_pos <= '0;
            key_err   <= 1'b0;
        end else begin
            state     <= state_d;
            set_req   <= req_d;
            dig_q     <= dig_d;
            digit_pos <= pos_d;
            key_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus randomized keypad traffic against a behavioural model.
// Build with or without SECONDS_SET_EN; the model follows the same macro.
module tb_time_set_ctrl;

    localparam int TO = 10;
`ifdef SECONDS_SET_EN
    localparam int ND = 6;
`else
    localparam int ND = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       set_ack = 1'b0;
    logic       set_req;
    logic [7:0] set_hh, set_mm;
`ifdef SECONDS_SET_EN
    logic [7:0] set_ss;
`endif
    logic [2:0] digit_pos;
    logic [1:0] state;
    logic       key_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: state 0 idle, 1 entry, 2 confirm, 3 commit; digits as integers.
    int m_state = 0, m_pos = 0, m_idle = 0;
    int m_dig [6] = '{0, 0, 0, 0, 0, 0};
    bit m_req = 1'b0, m_err = 1'b0;

    always #5 clk = ~clk;

    time_set_ctrl #(.TIMEOUT_S(TO), .KEY_A(4'd10)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .key_valid (key_valid),
        .key_code  (key_code),
        .set_ack   (set_ack),
        .set_req   (set_req),
        .set_hh    (set_hh),
        .set_mm    (set_mm),
`ifdef SECONDS_SET_EN
        .set_ss    (set_ss),
`endif
        .digit_pos (digit_pos),
        .state     (state),
        .key_err   (key_err)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // A digit is legal when the partial time can still become a valid 00:00:00-23:59:59.
    function automatic bit legal(input int pos, input int d);
        case (pos)
            0:       return (d <= 2) && (10 * d + m_dig[1] <= 23);
            1:       return (10 * m_dig[0] + d <= 23);
            2, 4:    return (10 * d <= 59);
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit t, input bit kv, input int kc, input bit ack);
        if (r) begin
            m_state = 0; m_pos = 0; m_idle = 0; m_req = 0; m_err = 0;
            for (int i = 0; i < 6; i++) m_dig[i] = 0;
            return;
        end
        m_err = 0;
        case (m_state)
            0: if (kv && kc == 10) begin
                for (int i = 0; i < 6; i++) m_dig[i] = 0;
                m_pos = 0;
                m_state = 1;
            end
            1, 2: begin
                if (kv) begin
                    m_idle = 0;
                    if (kc == 11) begin
                        m_state = 0;
                    end else if (m_state == 1) begin
                        if (kc == 13) begin
                            if (m_pos > 0) begin
                                m_pos--;
                                m_dig[m_pos] = 0;
                            end
                        end else if (kc <= 9) begin
                            if (legal(m_pos, kc)) begin
                                m_dig[m_pos] = kc;
                                if (m_pos == ND - 1) m_state = 2;
                                else m_pos++;
                            end else begin
                                m_err = 1;
                            end
                        end
                    end else begin
                        if (kc == 10) begin
                            m_req = 1;
                            m_state = 3;
                        end else if (kc == 13) begin
                            m_dig[ND-1] = 0;
                            m_state = 1;
                        end
                    end
                end else if (t) begin
                    m_idle++;
                    if (m_idle >= TO) m_state = 0;
                end
            end
            default: if (ack) begin
                m_req = 0;
                m_state = 0;
            end
        endcase
        if (m_state == 0 || m_state == 3) m_idle = 0;
    endtask

    task automatic check_all();
        check("state", 8'(state), 8'(m_state));
        check("set_req", 8'(set_req), 8'(m_req));
        check("set_hh", set_hh, 8'(m_dig[0] * 16 + m_dig[1]));
        check("set_mm", set_mm, 8'(m_dig[2] * 16 + m_dig[3]));
`ifdef SECONDS_SET_EN
        check("set_ss", set_ss, 8'(m_dig[4] * 16 + m_dig[5]));
`endif
        check("digit_pos", 8'(digit_pos), 8'(m_pos));
        check("key_err", 8'(key_err), 8'(m_err));
    endtask

    task automatic cyc(input bit r, input bit t, input bit kv, input int kc, input bit ack);
        @(negedge clk);
        rst = r; tick_1hz = t; key_valid = kv; key_code = 4'(kc); set_ack = ack;
        @(posedge clk);
        model_step(r, t, kv, kc, ack);
        #1;
        check_all();
    endtask

    task automatic key(input int kc);
        cyc(1'b0, 1'b0, 1'b1, kc, 1'b0);
    endtask

    task automatic idle(input bit t);
        cyc(1'b0, t, 1'b0, 0, 1'b0);
    endtask

    task automatic pad_seconds();
        for (int i = 4; i < ND; i++) key(0);
    endtask

    int len, kp, sel, kc;
    bit r, t, kv, ack;

    initial begin
        // Reset, including spurious key and ack while held
        cyc(1'b1, 1'b0, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 10, 1'b1);
        check("rst_state", 8'(state), 8'h00);
        check("rst_req", 8'(set_req), 8'h00);
        check("rst_pos", 8'(digit_pos), 8'h00);
        check("rst_hh", set_hh, 8'h00);

        // Ignored keys in IDLE, ack outside COMMIT
        key(5); key(13); cyc(1'b0, 1'b0, 1'b0, 0, 1'b1);
        check("idle_ignore", 8'(state), 8'h00);

        // Basic commit with ack two cycles after request
        key(10); key(1); key(2); key(3); key(4); pad_seconds();
        check("confirm_state", 8'(state), 8'h02);
        key(10);
        check("commit_req", 8'(set_req), 8'h01);
        idle(1'b0); idle(1'b0);
        check("req_held", 8'(set_req), 8'h01);
        cyc(1'b0, 1'b0, 1'b0, 0, 1'b1);
        check("req_drop", 8'(set_req), 8'h00);
        check("commit_idle", 8'(state), 8'h00);
        check("commit_hh", set_hh, 8'h12);
        check("commit_mm", set_mm, 8'h34);

        // Illegal hour units after tens 2
        key(10); key(2); key(5);
        check("err_pulse", 8'(key_err), 8'h01);
        check("err_pos", 8'(digit_pos), 8'h01);
        key(3);
        check("err_clear", 8'(key_err), 8'h00);
        check("hh_23", set_hh, 8'h23);
        key(11);
        check("cancel_idle", 8'(state), 8'h00);

        // Backspace past the start
        key(10); key(1); key(13); key(13); key(0);
        check("bs_hh", set_hh, 8'h00);
        check("bs_pos", 8'(digit_pos), 8'h01);
        key(11);

        // Inactivity timeout, then key+tick coincidence restarting the count
        key(10); key(1);
        repeat (TO - 1) idle(1'b1);
        check("pre_timeout", 8'(state), 8'h01);
        idle(1'b1);
        check("timeout", 8'(state), 8'h00);
        check("timeout_req", 8'(set_req), 8'h00);
        key(10); key(1);
        repeat (TO - 1) idle(1'b1);
        cyc(1'b0, 1'b1, 1'b1, 2, 1'b0);
        repeat (TO - 1) idle(1'b1);
        check("key_beats_tick", 8'(state), 8'h01);
        idle(1'b1);
        check("timeout_2", 8'(state), 8'h00);

        // Digit limits and backspace out of CONFIRM
        key(10); key(3);
        check("tens_3", 8'(key_err), 8'h01);
        check("tens_3_pos", 8'(digit_pos), 8'h00);
        key(2); key(4);
        check("units_4", 8'(key_err), 8'h01);
        key(3); key(6);
        check("min_tens_6", 8'(key_err), 8'h01);
        key(5); key(9); pad_seconds();
        check("confirm2", 8'(state), 8'h02);
        key(13);
        check("bs_confirm", 8'(state), 8'h01);
        check("bs_confirm_pos", 8'(digit_pos), 8'(ND - 1));
        key(7);
        check("reconfirm", 8'(state), 8'h02);
        key(11);
        check("cancel_confirm", 8'(state), 8'h00);
        check("cancel_no_req", 8'(set_req), 8'h00);

        // COMMIT ignores digits, B and timeout; reset aborts it
        key(10); key(1); key(2); key(3); key(4); pad_seconds();
        key(5);
        check("confirm_digit", 8'(state), 8'h02);
        key(10); key(11);
        check("commit_b", 8'(state), 8'h03);
        repeat (TO + 2) idle(1'b1);
        check("commit_no_to", 8'(set_req), 8'h01);
        cyc(1'b1, 1'b0, 1'b0, 0, 1'b0);
        check("rst_commit_req", 8'(set_req), 8'h00);
        check("rst_commit_st", 8'(state), 8'h00);

`ifdef SECONDS_SET_EN
        key(10); key(0); key(9); key(5); key(9); key(4); key(5); key(10);
        check("sec_hh", set_hh, 8'h09);
        check("sec_mm", set_mm, 8'h59);
        check("sec_ss", set_ss, 8'h45);
        cyc(1'b0, 1'b0, 1'b0, 0, 1'b1);
`endif

        // Randomized traffic, with some key-free stretches to provoke timeouts
        for (int seg = 0; seg < 60; seg++) begin
            len = $urandom_range(20, 150);
            kp  = (seg % 4 == 0) ? 0 : $urandom_range(5, 50);
            for (int c = 0; c < len; c++) begin
                r   = ($urandom_range(0, 499) == 0);
                t   = ($urandom_range(0, 5) == 0);
                kv  = ($urandom_range(0, 99) < kp);
                ack = ($urandom_range(0, 3) == 0);
                sel = $urandom_range(0, 99);
                if (sel < 50)      kc = $urandom_range(0, 9);
                else if (sel < 65) kc = 10;
                else if (sel < 70) kc = 11;
                else if (sel < 88) kc = 13;
                else               kc = $urandom_range(12, 15);
                cyc(r, t, kv, kc, ack);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
